sdram_access_arbiter: RTL and testbench

- Owns the single jsv_sdram bridge port and shares it between two requesters: the fractal_calc pixel writer and the VGA line-prefetch reader.
- Writes are buffered in a small FIFO. The reader issues fixed-length sequential read bursts and has priority.
- All bridge commands are registered and follow a hold-until-acknowledge handshake.
- Sits between fractal_calc, the VGA interface line buffer, and jsv_sdram.

---
 rtl/jsv_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/sdram_access_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_access_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jsv_pkg.sv
// Shared types and constants for the SDRAM access arbiter.
//   arb_state_t    - arbiter FSM states (IDLE, WRITE, READ)
//   JSV_*          - default geometry, bridge address width and byte-enable value
//   wr_entry_t     - one buffered pixel write: word address plus 8-bit data
//   pixel_addr()   - full-width linear address y*h_res + x (no truncation)
package jsv_pkg;

    localparam int         JSV_ADDR_W     = 19;
    localparam int         JSV_H_RES      = 640;
    localparam int         JSV_V_RES      = 480;
    localparam logic [3:0] JSV_BR_BYTE_EN = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [JSV_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } wr_entry_t;

    // 32-bit result so out-of-range coordinates can still be compared
    // against the bridge address space before any narrowing.
    function automatic logic [31:0] pixel_addr(input logic [9:0] x,
                                               input logic [8:0] y,
                                               input int         h_res);
        return 32'(y) * 32'(h_res) + 32'(x);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with a registered RAM read.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i/wdata_i  - write side (ignored while full)
//   pop_i           - consume the head (ignored while head_valid_o is low)
//   rdata_o         - registered head entry
//   head_valid_o    - rdata_o holds the current head
//   full_o, empty_o - derived from the registered occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             head_valid_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             head_valid_q;
    logic             head_valid_d;
    logic             push_en;
    logic             pop_en;

    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign rdata_o      = head_q;
    assign head_valid_o = head_valid_q;

    assign push_en  = push_i && !full_o;
    assign pop_en   = pop_i && head_valid_q;
    assign count_d  = count_q + CW'(push_en) - CW'(pop_en);
    assign rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // When the entry being pushed is the one the head register is about
    // to read, the RAM still returns the old word this edge; the head only
    // becomes valid one cycle later.
    assign head_valid_d = (count_d != '0) &&
                          !(push_en && (count_q == CW'(pop_en)));

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
        head_q <= mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
        end
    end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares the single jsv_sdram bridge port between the fractal pixel writer
// and the VGA line-prefetch reader. Writes are buffered in a small FIFO;
// read bursts have strict priority and are never interrupted by writes.
//   CLK, RESET           - 50 MHz clock, asynchronous active-low reset
//   WR_*                 - pixel write request (X, Y, DATA), ready and drop pulse
//   RD_*                 - burst request/base, busy, returned words, done and error pulses
//   BR_*                 - registered bridge command with hold-until-ack handshake
module sdram_access_arbiter
    import jsv_pkg::*;
#(
    parameter int ADDR_W      = JSV_ADDR_W,
    parameter int H_RES       = JSV_H_RES,
    parameter int V_RES       = JSV_V_RES,
    parameter int WFIFO_DEPTH = 8,
    parameter int BURST_LEN   = 80
) (
    input  logic              CLK,
    input  logic              RESET,
    // pixel writer
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [9:0]        WR_X,
    input  logic [8:0]        WR_Y,
    input  logic [7:0]        WR_DATA,
    output logic              WR_DROP,
    // line-prefetch reader
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_BASE,
    output logic              RD_BUSY,
    output logic              RD_VALID,
    output logic [15:0]       RD_DATA,
    output logic              RD_DONE,
    output logic              RD_ERR,
    // bridge
    output logic [ADDR_W-1:0] BR_ADDR,
    output logic [3:0]        BR_BYTE_EN,
    output logic              BR_READ,
    output logic              BR_WRITE,
    output logic [15:0]       BR_WRITE_DATA,
    input  logic              BR_ACK,
    input  logic [15:0]       BR_READ_DATA
);

    localparam int               CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    // ---------------------------------------------------------------
    // Write path: address computation, range check, FIFO
    // ---------------------------------------------------------------
    logic [31:0] wr_lin;
    logic        wr_in_range;
    logic        wr_acc;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_head_valid;
    wr_entry_t   fifo_wdata;
    wr_entry_t   fifo_head;
    logic        ready_en_q;

    assign wr_lin = pixel_addr(WR_X, WR_Y, H_RES);

    // The whole product is checked against the bridge address space, so a
    // geometry that overflows the bridge is dropped rather than aliased.
    assign wr_in_range = (32'(WR_X) < 32'(H_RES)) &&
                         (32'(WR_Y) < 32'(V_RES)) &&
                         ((wr_lin >> JSV_ADDR_W) == 32'd0);

    // ready_en_q keeps WR_READY low while reset is held.
    assign WR_READY  = ready_en_q && !fifo_full;
    assign wr_acc    = WR_VALID && WR_READY;
    assign fifo_push = wr_acc && wr_in_range;

    assign fifo_wdata.addr = JSV_ADDR_W'(wr_lin);
    assign fifo_wdata.data = WR_DATA;

    sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .push_i       (fifo_push),
        .wdata_i      (fifo_wdata),
        .pop_i        (fifo_pop),
        .rdata_o      (fifo_head),
        .head_valid_o (fifo_head_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // ---------------------------------------------------------------
    // Arbiter FSM, burst bookkeeping and registered bridge command
    // ---------------------------------------------------------------
    arb_state_t        state_q;
    logic              pending_q;
    logic              fresh_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] br_addr_q;
    logic [15:0]       br_wdata_q;
    logic              br_read_q;
    logic              br_write_q;
    logic              rd_valid_q;
    logic [15:0]       rd_data_q;
    logic              rd_done_q;
    logic              rd_err_q;
    logic              wr_drop_q;

    // The bridge command is held until BR_ACK, so the head is consumed on the ack edge.
    assign fifo_pop = (state_q == WRITE) && BR_ACK;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            pending_q  <= 1'b0;
            fresh_q    <= 1'b0;
            base_q     <= '0;
            cnt_q      <= '0;
            br_addr_q  <= '0;
            br_wdata_q <= '0;
            br_read_q  <= 1'b0;
            br_write_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            fresh_q    <= 1'b0;
            wr_drop_q  <= wr_acc && !wr_in_range;
            rd_err_q   <= RD_REQ && pending_q;

            if (RD_REQ && !pending_q) begin
                pending_q <= 1'b1;
                fresh_q   <= 1'b1;
                base_q    <= RD_BASE;
                cnt_q     <= '0;
            end

            case (state_q)
                IDLE: begin
                    // fresh_q holds a new burst back one cycle so a read
                    // command leaves two edges after its request, the same
                    // spacing a write sees through the FIFO head register.
                    if (pending_q && !fresh_q) begin
                        state_q   <= READ;
                        br_read_q <= 1'b1;
                        br_addr_q <= base_q + ADDR_W'(cnt_q);
                    end else if (!fifo_empty && fifo_head_valid) begin
                        state_q    <= WRITE;
                        br_write_q <= 1'b1;
                        br_addr_q  <= ADDR_W'(fifo_head.addr);
                        br_wdata_q <= {8'h00, fifo_head.data};
                    end
                end
                WRITE: begin
                    if (BR_ACK) begin
                        br_write_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                READ: begin
                    if (BR_ACK) begin
                        br_read_q  <= 1'b0;
                        state_q    <= IDLE;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= BR_READ_DATA;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            rd_done_q <= 1'b1;
                            pending_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WR_DROP       = wr_drop_q;
    assign RD_BUSY       = pending_q;
    assign RD_VALID      = rd_valid_q;
    assign RD_DATA       = rd_data_q;
    assign RD_DONE       = rd_done_q;
    assign RD_ERR        = rd_err_q;
    assign BR_ADDR       = br_addr_q;
    assign BR_BYTE_EN    = JSV_BR_BYTE_EN;
    assign BR_READ       = br_read_q;
    assign BR_WRITE      = br_write_q;
    assign BR_WRITE_DATA = br_wdata_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter with a small bridge responder.
module tb_sdram_access_arbiter;

    localparam int ADDR_W = 19;
    localparam int BURST  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [9:0]        wr_x = '0;
    logic [8:0]        wr_y = '0;
    logic [7:0]        wr_data = '0;
    logic              wr_drop;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_base = '0;
    logic              rd_busy;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic              rd_done;
    logic              rd_err;
    logic [ADDR_W-1:0] br_addr;
    logic [3:0]        br_byte_en;
    logic              br_read;
    logic              br_write;
    logic [15:0]       br_wdata;
    logic              br_ack = 1'b0;
    logic [15:0]       br_rdata = '0;

    int checks = 0;
    int errors = 0;

    bit ack_en    = 1'b0;
    int ack_delay = 0;
    int ack_wait  = 0;

    typedef struct { bit wr; int addr; int data; } br_txn_t;
    typedef struct { int data; bit done; } rd_beat_t;
    br_txn_t  br_log[$];
    rd_beat_t rd_log[$];
    br_txn_t  txn;
    rd_beat_t beat;

    int   acc, k, hi;
    logic rdy;
    int   pri_addr[7];
    bit   pri_wr[7];

    sdram_access_arbiter #(
        .ADDR_W      (ADDR_W),
        .H_RES       (640),
        .V_RES       (480),
        .WFIFO_DEPTH (8),
        .BURST_LEN   (BURST)
    ) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .WR_VALID      (wr_valid),
        .WR_READY      (wr_ready),
        .WR_X          (wr_x),
        .WR_Y          (wr_y),
        .WR_DATA       (wr_data),
        .WR_DROP       (wr_drop),
        .RD_REQ        (rd_req),
        .RD_BASE       (rd_base),
        .RD_BUSY       (rd_busy),
        .RD_VALID      (rd_valid),
        .RD_DATA       (rd_data),
        .RD_DONE       (rd_done),
        .RD_ERR        (rd_err),
        .BR_ADDR       (br_addr),
        .BR_BYTE_EN    (br_byte_en),
        .BR_READ       (br_read),
        .BR_WRITE      (br_write),
        .BR_WRITE_DATA (br_wdata),
        .BR_ACK        (br_ack),
        .BR_READ_DATA  (br_rdata)
    );

    always #5 clk = ~clk;

    // Bridge responder: acks ack_delay cycles after the strobe is seen,
    // read data = address + 0x1234. One line per bridge transaction.
    always @(posedge clk) begin
        #1;
        if (br_ack) begin
            br_ack   = 1'b0;
            ack_wait = 0;
        end else if ((br_read || br_write) && ack_en && rst_n) begin
            if (ack_wait >= ack_delay) begin
                br_ack   = 1'b1;
                ack_wait = 0;
                if (br_read) br_rdata = 16'(br_addr) + 16'h1234;
                txn.wr   = br_write;
                txn.addr = int'(br_addr);
                txn.data = br_write ? int'(br_wdata) : int'(br_rdata);
                br_log.push_back(txn);
                $display("bridge %s addr=%0d data=%h", br_write ? "WR" : "RD", txn.addr, txn.data[15:0]);
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (rd_valid) begin
            beat.data = int'(rd_data);
            beat.done = rd_done;
            rd_log.push_back(beat);
            $display("read beat data=%h done=%0d", rd_data, rd_done);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int w;
        w = 0;
        while (br_log.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(tag, br_log.size(), n);
    endtask

    task automatic write_one(input logic [9:0] x, input logic [8:0] y, input logic [7:0] d);
        @(negedge clk);
        wr_valid = 1'b1; wr_x = x; wr_y = y; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd_request(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        rd_req = 1'b1; rd_base = base;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        pri_addr = '{1930, 1000, 1001, 1002, 1003, 1931, 1932};
        pri_wr   = '{1, 0, 0, 0, 0, 1, 1};

        // ---- reset state ----
        #3;
        check("rst_br_read",  br_read, 0);
        check("rst_br_write", br_write, 0);
        check("rst_rd_busy",  rd_busy, 0);
        check("rst_byte_en",  br_byte_en, 4'b0011);
        check("rst_rd_valid", rd_valid, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rel_wr_ready", wr_ready, 1);
        check("rel_br_write", br_write, 0);
        check("rel_rd_busy",  rd_busy, 0);
        check("rel_byte_en",  br_byte_en, 4'b0011);

        // ---- single write, ack 3 cycles after strobe ----
        ack_en = 1'b1; ack_delay = 3; br_log.delete();
        write_one(10'd5, 9'd2, 8'hAB);
        check("wr_lat_t1", br_write, 0);
        tick(1);
        check("wr_lat_t2", br_write, 0);
        tick(1);
        check("wr_lat_rise", br_write, 1);
        check("wr_addr", br_addr, 1285);
        check("wr_data", br_wdata, 16'h00AB);
        hi = 1; k = 0;
        while (!br_ack && k < 20) begin
            tick(1);
            if (br_write) hi++;
            k++;
        end
        check("wr_hold_cycles", hi, 4);
        tick(1);
        check("wr_drop_after_ack", br_write, 0);
        check("wr_single_txn", br_log.size(), 1);

        // ---- backpressure: ack held off, 9 back-to-back writes ----
        ack_en = 1'b0; br_log.delete(); acc = 0;
        tick(2);
        for (int c = 0; c < 14 && acc < 9; c++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_x = 10'(acc); wr_y = 9'd1; wr_data = 8'(16 + acc);
            rdy = wr_ready;
            @(posedge clk);
            if (rdy) acc++;
        end
        @(negedge clk);
        check("bp_accepted", acc, 8);
        check("bp_wr_ready_low", wr_ready, 0);
        ack_en = 1'b1; ack_delay = 0;
        for (int c = 0; c < 20 && acc < 9; c++) begin
            rdy = wr_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("bp_accepted_all", acc, 9);
        wait_log("bp_drain_count", 9, 80);
        for (int i = 0; i < 9 && i < br_log.size(); i++) begin
            check("bp_addr", br_log[i].addr, 640 + i);
            check("bp_data", br_log[i].data, 16 + i);
        end

        // ---- read priority over queued writes ----
        tick(3);
        ack_en = 1'b0; br_log.delete(); rd_log.delete();
        write_one(10'd10, 9'd3, 8'h21);
        write_one(10'd11, 9'd3, 8'h22);
        write_one(10'd12, 9'd3, 8'h23);
        rd_request(19'd1000);
        tick(2);
        check("pri_busy", rd_busy, 1);
        ack_en = 1'b1; ack_delay = 0;
        wait_log("pri_count", 7, 80);
        for (int i = 0; i < 7 && i < br_log.size(); i++) begin
            check("pri_addr", br_log[i].addr, pri_addr[i]);
            check("pri_kind", br_log[i].wr, pri_wr[i]);
        end
        tick(3);
        check("pri_beats", rd_log.size(), BURST);
        for (int i = 0; i < BURST && i < rd_log.size(); i++) begin
            check("pri_rd_data", rd_log[i].data, 1000 + 16'h1234 + i);
            check("pri_rd_done", rd_log[i].done, (i == BURST - 1) ? 1 : 0);
        end
        check("pri_busy_end", rd_busy, 0);

        // ---- RD_REQ while busy ----
        ack_en = 1'b0; br_log.delete(); rd_log.delete();
        rd_request(19'd2000);
        tick(1);
        check("rd_lat_t1", br_read, 0);
        tick(1);
        check("rd_lat_rise", br_read, 1);
        check("err_addr_before", br_addr, 2000);
        rd_request(19'd3000);
        check("err_pulse", rd_err, 1);
        tick(1);
        check("err_pulse_end", rd_err, 0);
        check("err_addr_hold", br_addr, 2000);
        ack_en = 1'b1;
        wait_log("err_count", 4, 60);
        for (int i = 0; i < 4 && i < br_log.size(); i++)
            check("err_burst_addr", br_log[i].addr, 2000 + i);
        tick(3);
        check("err_beats", rd_log.size(), 4);
        check("err_busy_end", rd_busy, 0);

        // ---- out-of-range writes and the last valid pixel ----
        br_log.delete();
        write_one(10'd700, 9'd0, 8'h55);
        check("drop_x_pulse", wr_drop, 1);
        tick(1);
        check("drop_x_end", wr_drop, 0);
        write_one(10'd0, 9'd480, 8'h56);
        check("drop_y_pulse", wr_drop, 1);
        tick(6);
        check("drop_no_write", br_log.size(), 0);
        write_one(10'd639, 9'd479, 8'h57);
        check("edge_no_drop", wr_drop, 0);
        wait_log("edge_count", 1, 20);
        if (br_log.size() > 0) check("edge_addr", br_log[0].addr, 307199);

        // ---- asynchronous reset in the middle of a read ----
        tick(3);
        ack_en = 1'b0; br_log.delete(); rd_log.delete();
        rd_request(19'd500);
        k = 0;
        while (!br_read && k < 10) begin tick(1); k++; end
        check("mid_strobe", br_read, 1);
        write_one(10'd1, 9'd1, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_br_read", br_read, 0);
        check("async_rd_busy", rd_busy, 0);
        tick(2);
        rst_n = 1'b1;
        ack_en = 1'b1;
        tick(10);
        check("post_rst_no_bridge", br_log.size(), 0);
        check("post_rst_no_rdvalid", rd_log.size(), 0);
        check("post_rst_wr_ready", wr_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
